// File: rtl/systolic_pkg.sv
// Shared types and helpers for the NxN output-stationary systolic multiplier.
//   state_e            : controller states
//   compute_steps(n)   : number of COMPUTE cycles for an n x n array (3n-2)
//   acc_width_default  : accumulator width that holds n full-width products
package systolic_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COMPUTE = 2'd1,
      DONE    = 2'd2
   } state_e;

   // Last product lands in PE(n-1,n-1) at step 3n-3, so steps 0..3n-3 are needed.
   function automatic int unsigned compute_steps(input int unsigned n);
      return 3 * n - 2;
   endfunction

   function automatic int unsigned acc_width_default(input int unsigned op_w,
                                                     input int unsigned n);
      return 2 * op_w + $clog2(n);
   endfunction

endpackage

// File: rtl/systolic_pe.sv
// One multiply-accumulate cell of the systolic array.
// Ports:
//   clk, reset_n   : clock, asynchronous active-low reset
//   en             : accumulate and forward this cycle
//   clr            : synchronously zero accumulator and forwarding registers
//   a_in / a_out   : row operand in from the left, registered copy to the right
//   b_in / b_out   : column operand in from above, registered copy downward
//   acc            : running accumulator (wraps modulo 2^ACC_WIDTH)
// Build option: SYSTOLIC_SIGNED_EN selects two's-complement arithmetic.
module systolic_pe #(
   parameter int unsigned OP_WIDTH  = 8,
   parameter int unsigned ACC_WIDTH = 18
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 en,
   input  logic                 clr,
   input  logic [OP_WIDTH-1:0]  a_in,
   input  logic [OP_WIDTH-1:0]  b_in,
   output logic [OP_WIDTH-1:0]  a_out,
   output logic [OP_WIDTH-1:0]  b_out,
   output logic [ACC_WIDTH-1:0] acc
);

   localparam int unsigned PW = 2 * OP_WIDTH;

   logic [OP_WIDTH-1:0]  a_q, a_d;
   logic [OP_WIDTH-1:0]  b_q, b_d;
   logic [ACC_WIDTH-1:0] acc_q, acc_d;
   logic [PW-1:0]        prod_c;
   logic [ACC_WIDTH-1:0] prod_ext_c;

   // Full-width product, then extended to the accumulator width.
`ifdef SYSTOLIC_SIGNED_EN
   assign prod_c     = PW'($signed(a_in)) * PW'($signed(b_in));
   assign prod_ext_c = ACC_WIDTH'($signed(prod_c));
`else
   assign prod_c     = PW'(a_in) * PW'(b_in);
   assign prod_ext_c = ACC_WIDTH'(prod_c);
`endif

   // Next-state: clear wins over accumulate; otherwise hold.
   always_comb begin
      a_d   = a_q;
      b_d   = b_q;
      acc_d = acc_q;
      if (clr) begin
         a_d   = '0;
         b_d   = '0;
         acc_d = '0;
      end else if (en) begin
         a_d   = a_in;
         b_d   = b_in;
         acc_d = acc_q + prod_ext_c;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         a_q   <= '0;
         b_q   <= '0;
         acc_q <= '0;
      end else begin
         a_q   <= a_d;
         b_q   <= b_d;
         acc_q <= acc_d;
      end
   end

   assign a_out = a_q;
   assign b_out = b_q;
   assign acc   = acc_q;

endmodule

// File: rtl/systolic_matmul_nxn.sv
// NxN output-stationary systolic matrix multiplier, C = A x B.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   start/ready  : request handshake; operands captured when start && ready
//   A, B         : row-major operand matrices, OP_WIDTH per element
//   C            : row-major result, ACC_WIDTH per element, held until next accept
//   c_valid/c_ready : result handshake
//   busy         : high while the array is computing
// Build option: SYSTOLIC_SIGNED_EN selects two's-complement arithmetic in the PEs.
// N must be at least 2.
module systolic_matmul_nxn
   import systolic_pkg::*;
#(
   parameter int unsigned N         = 4,
   parameter int unsigned OP_WIDTH  = 8,
   parameter int unsigned ACC_WIDTH = acc_width_default(OP_WIDTH, N)
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       start,
   output logic                       ready,
   input  logic [N*N*OP_WIDTH-1:0]    A,
   input  logic [N*N*OP_WIDTH-1:0]    B,
   output logic [N*N*ACC_WIDTH-1:0]   C,
   output logic                       c_valid,
   input  logic                       c_ready,
   output logic                       busy
);

   localparam int unsigned STEPS = compute_steps(N);
   localparam int unsigned SW    = $clog2(STEPS);
   localparam int unsigned MW    = N * N * OP_WIDTH;

   state_e            state_q, state_d;
   logic [SW-1:0]     step_q, step_d;
   logic [MW-1:0]     op_a_q, op_a_d;
   logic [MW-1:0]     op_b_q, op_b_d;
   logic              ready_q, ready_d;
   logic              busy_q, busy_d;
   logic              c_valid_q, c_valid_d;
   logic              clr_c;
   logic              en_c;

   logic [OP_WIDTH-1:0] left_c [N];
   logic [OP_WIDTH-1:0] top_c  [N];
   logic [OP_WIDTH-1:0] a_h    [N][N+1];
   logic [OP_WIDTH-1:0] b_v    [N+1][N];

   // Controller next-state and registered-output decode.
   always_comb begin
      state_d = state_q;
      step_d  = step_q;
      op_a_d  = op_a_q;
      op_b_d  = op_b_q;
      clr_c   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               op_a_d  = A;
               op_b_d  = B;
               step_d  = '0;
               clr_c   = 1'b1;
               state_d = COMPUTE;
            end
         end
         COMPUTE: begin
            if (step_q == SW'(STEPS - 1)) begin
               state_d = DONE;
            end else begin
               step_d = step_q + SW'(1);
            end
         end
         DONE: begin
            if (c_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      ready_d   = (state_d == IDLE);
      busy_d    = (state_d == COMPUTE);
      c_valid_d = (state_d == DONE);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         step_q    <= '0;
         op_a_q    <= '0;
         op_b_q    <= '0;
         ready_q   <= 1'b1;
         busy_q    <= 1'b0;
         c_valid_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         step_q    <= step_d;
         op_a_q    <= op_a_d;
         op_b_q    <= op_b_d;
         ready_q   <= ready_d;
         busy_q    <= busy_d;
         c_valid_q <= c_valid_d;
      end
   end

   assign en_c    = (state_q == COMPUTE);
   assign ready   = ready_q;
   assign busy    = busy_q;
   assign c_valid = c_valid_q;

   // Edge skew: at step t row i sees A(i,t-i), column j sees B(t-j,j); zero otherwise.
   always_comb begin
      for (int i = 0; i < int'(N); i++) begin
         left_c[i] = '0;
         top_c[i]  = '0;
         for (int k = 0; k < int'(N); k++) begin
            if (en_c && (int'(step_q) == i + k)) begin
               left_c[i] = op_a_q[(i * int'(N) + k) * int'(OP_WIDTH) +: OP_WIDTH];
               top_c[i]  = op_b_q[(k * int'(N) + i) * int'(OP_WIDTH) +: OP_WIDTH];
            end
         end
      end
   end

   // PE mesh: A flows right along rows, B flows down columns.
   for (genvar i = 0; i < N; i++) begin : g_row
      assign a_h[i][0] = left_c[i];
      assign b_v[0][i] = top_c[i];
      for (genvar j = 0; j < N; j++) begin : g_col
         systolic_pe #(
            .OP_WIDTH  (OP_WIDTH),
            .ACC_WIDTH (ACC_WIDTH)
         ) u_pe (
            .clk     (clk),
            .reset_n (reset_n),
            .en      (en_c),
            .clr     (clr_c),
            .a_in    (a_h[i][j]),
            .b_in    (b_v[i][j]),
            .a_out   (a_h[i][j+1]),
            .b_out   (b_v[i+1][j]),
            .acc     (C[(i*N+j)*ACC_WIDTH +: ACC_WIDTH])
         );
      end
   end

endmodule

// File: tb/tb_systolic_matmul_nxn.sv
// Directed bench for systolic_matmul_nxn: an N=2 (ACC_WIDTH=16) and an N=4 instance.
module tb_systolic_matmul_nxn;

   localparam int unsigned OPW  = 8;
   localparam int unsigned ACC2 = 16;
   localparam int unsigned ACC4 = 2 * OPW + 2;

   logic clk = 1'b0;
   logic reset_n;
   always #5 clk = ~clk;

   logic                 start2, rdy2, cv2, cr2, busy2;
   logic [4*OPW-1:0]     a2, b2;
   logic [4*ACC2-1:0]    c2;
   logic                 start4, rdy4, cv4, cr4, busy4;
   logic [16*OPW-1:0]    a4, b4;
   logic [16*ACC4-1:0]   c4;

   int n_run  = 0;
   int n_fail = 0;

   systolic_matmul_nxn #(.N(2), .OP_WIDTH(OPW), .ACC_WIDTH(ACC2)) u_dut2 (
      .clk(clk), .reset_n(reset_n), .start(start2), .ready(rdy2),
      .A(a2), .B(b2), .C(c2), .c_valid(cv2), .c_ready(cr2), .busy(busy2)
   );

   systolic_matmul_nxn #(.N(4), .OP_WIDTH(OPW)) u_dut4 (
      .clk(clk), .reset_n(reset_n), .start(start4), .ready(rdy4),
      .A(a4), .B(b4), .C(c4), .c_valid(cv4), .c_ready(cr4), .busy(busy4)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Accept a job on the N=2 instance and wait for c_valid, checking the latency.
   task automatic run2(input logic [4*OPW-1:0] a, input logic [4*OPW-1:0] b);
      int lat;
      @(negedge clk);
      a2 = a; b2 = b; start2 = 1'b1;
      @(negedge clk);
      start2 = 1'b0; a2 = '1; b2 = '1;
      check("n2 ready low", 64'(rdy2), 64'd0);
      check("n2 busy", 64'(busy2), 64'd1);
      lat = 0;
      while (!cv2 && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      check("n2 latency", 64'(lat), 64'd4);
   endtask

   task automatic run4(input logic [16*OPW-1:0] a, input logic [16*OPW-1:0] b);
      int lat;
      @(negedge clk);
      a4 = a; b4 = b; start4 = 1'b1;
      @(negedge clk);
      start4 = 1'b0; a4 = '0; b4 = '0;
      lat = 0;
      while (!cv4 && lat < 60) begin
         @(negedge clk);
         lat++;
      end
      check("n4 latency", 64'(lat), 64'd10);
   endtask

   task automatic check_c2(input string tag, input logic [63:0] e0, input logic [63:0] e1,
                           input logic [63:0] e2, input logic [63:0] e3);
      check({tag, " C00"}, 64'(c2[0*ACC2 +: ACC2]), e0);
      check({tag, " C01"}, 64'(c2[1*ACC2 +: ACC2]), e1);
      check({tag, " C10"}, 64'(c2[2*ACC2 +: ACC2]), e2);
      check({tag, " C11"}, 64'(c2[3*ACC2 +: ACC2]), e3);
   endtask

   // Compare every N=4 result element against the matching element of an operand matrix.
   task automatic check_c4(input string tag, input logic [16*OPW-1:0] m);
      for (int e = 0; e < 16; e++) begin
         check($sformatf("%s C[%0d]", tag, e), 64'(c4[e*ACC4 +: ACC4]), 64'(m[e*OPW +: OPW]));
      end
   endtask

   task automatic handshake2();
      @(negedge clk);
      cr2 = 1'b1;
      @(negedge clk);
      cr2 = 1'b0;
      check("n2 c_valid drop", 64'(cv2), 64'd0);
      check("n2 ready back", 64'(rdy2), 64'd1);
   endtask

   task automatic handshake4();
      @(negedge clk);
      cr4 = 1'b1;
      @(negedge clk);
      cr4 = 1'b0;
      check("n4 c_valid drop", 64'(cv4), 64'd0);
   endtask

   logic [16*OPW-1:0] ident, seq, seq2;
   logic [4*ACC2-1:0] snap;

   initial begin
      for (int i = 0; i < 4; i++) begin
         for (int j = 0; j < 4; j++) begin
            ident[(i*4+j)*OPW +: OPW] = (i == j) ? 8'd1 : 8'd0;
            seq[(i*4+j)*OPW +: OPW]   = OPW'(i*4 + j + 1);
            seq2[(i*4+j)*OPW +: OPW]  = OPW'(i*4 + j + 17);
         end
      end
      reset_n = 1'b0;
      start2 = 1'b0; cr2 = 1'b0; a2 = '0; b2 = '0;
      start4 = 1'b0; cr4 = 1'b0; a4 = '0; b4 = '0;
      repeat (2) @(negedge clk);
      check("rst ready", 64'(rdy2), 64'd1);
      check("rst busy", 64'(busy2), 64'd0);
      check("rst c_valid", 64'(cv2), 64'd0);
      check("rst C", 64'(c2), 64'd0);
      reset_n = 1'b1;

      // 2x2 basic product
      run2({8'd4, 8'd3, 8'd2, 8'd1}, {8'd8, 8'd7, 8'd6, 8'd5});
      check_c2("basic", 64'd19, 64'd22, 64'd43, 64'd50);

      // Backpressure: C held, start ignored while waiting for c_ready
      snap = c2;
      for (int k = 0; k < 5; k++) begin
         a2 = 32'hFFFF_FFFF ^ 32'(k); b2 = 32'h0102_0304 + 32'(k); start2 = 1'b1;
         @(negedge clk);
         check("bp C stable", 64'(c2), 64'(snap));
         check("bp ready", 64'(rdy2), 64'd0);
         check("bp c_valid", 64'(cv2), 64'd1);
         check("bp busy", 64'(busy2), 64'd0);
      end
      cr2 = 1'b1;  // start still high during the DONE handshake
      @(negedge clk);
      start2 = 1'b0; cr2 = 1'b0;
      check("bp c_valid drop", 64'(cv2), 64'd0);
      check("bp ready back", 64'(rdy2), 64'd1);
      check("bp no restart", 64'(busy2), 64'd0);
      check("bp C kept", 64'(c2), 64'(snap));
      @(negedge clk);
      check("bp still idle", 64'(busy2), 64'd0);

      // Overflow: all 255
      run2(32'hFFFF_FFFF, 32'hFFFF_FFFF);
`ifdef SYSTOLIC_SIGNED_EN
      check_c2("ovf", 64'd2, 64'd2, 64'd2, 64'd2);
`else
      check_c2("ovf", 64'd64514, 64'd64514, 64'd64514, 64'd64514);
`endif
      handshake2();

`ifdef SYSTOLIC_SIGNED_EN
      // Signed product: A=[[-1,2],[3,-4]], B=[[5,-6],[7,8]]
      run2({8'hFC, 8'd3, 8'd2, 8'hFF}, {8'd8, 8'd7, 8'hFA, 8'd5});
      check_c2("signed", 64'd9, 64'd22, 64'hFFF3, 64'hFFCE);
      handshake2();
`endif

      // 4x4: identity x B = B, then back-to-back A x identity = A
      run4(ident, seq);
      check_c4("IxB", seq);
      handshake4();
      run4(seq2, ident);
      check_c4("AxI", seq2);
      handshake4();

      // Reset at COMPUTE step 2
      @(negedge clk);
      a4 = ident; b4 = seq; start4 = 1'b1;
      @(negedge clk);
      start4 = 1'b0;
      repeat (2) @(negedge clk);
      check("mid busy", 64'(busy4), 64'd1);
      check("mid C00 partial", 64'(c4[0 +: ACC4]), 64'd1);
      reset_n = 1'b0;
      #1;
      check("mid rst ready", 64'(rdy4), 64'd1);
      check("mid rst busy", 64'(busy4), 64'd0);
      check("mid rst c_valid", 64'(cv4), 64'd0);
      check("mid rst C zero", 64'(c4 != '0), 64'd0);
      @(negedge clk);
      reset_n = 1'b1;
      run4(ident, seq);
      check_c4("post rst", seq);
      handshake4();

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
